// File: rtl/inst_mem_loader.sv
// Program loader for a 2**AW-word instruction memory: bytes stream in big-endian
// while the CPU is held in reset, then the memory serves combinational fetches.
module inst_mem_loader #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic [7:0]    ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   inst_adr,
  output logic [31:0]   inst,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [AW:0]   word_cnt;
  logic [AW:0]   len;
  logic [AW:0]   len_clamp;
  logic [AW:0]   word_inc;
  // Bytes 0..2 of the word under assembly; byte 3 is taken straight from ld_data.
  logic [31:8]   asm_hi;
  logic [31:0]   wr_word;
  logic          start_acc;
  logic          byte_acc;
  logic          word_wr;
  logic          addr_ok;
  logic [31:0]   mem [2**AW];

  always_comb begin
    start_acc = ld_start && (state != S_LOAD);
    byte_acc  = (state == S_LOAD) && ld_valid;
    word_wr   = byte_acc && (byte_cnt == 2'd3);
    len_clamp = (ld_len > DEPTH) ? DEPTH : ld_len;
    word_inc  = word_cnt + ONE;
    wr_word   = {asm_hi, ld_data};
    addr_ok   = (inst_adr[1:0] == 2'b00) && (inst_adr[31:AW+2] == '0);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_RUN: begin
        if (start_acc) state_nxt = (len_clamp == '0) ? S_RUN : S_LOAD;
      end
      S_LOAD: begin
        if (word_wr && (word_inc == len)) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      len      <= '0;
      err      <= 1'b0;
      asm_hi   <= '0;
    end else if (start_acc) begin
      len      <= len_clamp;
      byte_cnt <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if ((state == S_RUN) && !addr_ok) err <= 1'b1;
      if (byte_acc) begin
        unique case (byte_cnt)
          2'd0:    asm_hi[31:24] <= ld_data;
          2'd1:    asm_hi[23:16] <= ld_data;
          2'd2:    asm_hi[15:8]  <= ld_data;
          default: ;
        endcase
        byte_cnt <= byte_cnt + 2'd1;
        if (word_wr) word_cnt <= word_inc;
      end
    end
  end

  // Memory is never reset; rst only blocks a write on the same edge.
  always_ff @(posedge clk) begin
    if (rst && word_wr) mem[word_cnt[AW-1:0]] <= wr_word;
  end

  always_comb begin
    ld_ready = (state == S_LOAD);
    done     = (state == S_RUN);
    cpu_rst  = (state != S_RUN);
    inst     = (done && addr_ok) ? mem[inst_adr[AW+1:2]] : '0;
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: stimulus pushes expected outputs from a
// word-level memory model; a negedge monitor pops and compares on each probe.
module tb_inst_mem_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_start;
  logic [AW:0]   ld_len;
  logic [7:0]    ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   inst_adr;
  logic [31:0]   inst;
  logic          cpu_rst;
  logic          done;
  logic          err;

  inst_mem_loader #(.AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_len   (ld_len),
    .ld_data  (ld_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .inst_adr (inst_adr),
    .inst     (inst),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] inst;
    logic        err;
    logic        cpu_rst;
    logic        done;
    logic        ready;
  } exp_t;

  exp_t        sb[$];
  logic        probe;
  int          probe_id;
  int          vectors;
  int          miscompares;

  // Reference model: mode 0 idle, 1 loading, 2 running.
  logic [31:0] mem_m [DEPTH];
  bit          wr_m  [DEPTH];
  int          m_mode;
  bit          err_m;
  logic [7:0]  fixed_bytes[$];

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s probe#%0d actual=%08h expected=%08h", name, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (probe) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_underflow probe#%0d actual=empty expected=entry", probe_id);
      end else begin
        e = sb.pop_front();
        chk("inst",     e.tag, inst,            e.inst);
        chk("err",      e.tag, {31'd0, err},     {31'd0, e.err});
        chk("cpu_rst",  e.tag, {31'd0, cpu_rst}, {31'd0, e.cpu_rst});
        chk("done",     e.tag, {31'd0, done},    {31'd0, e.done});
        chk("ld_ready", e.tag, {31'd0, ld_ready},{31'd0, e.ready});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  function automatic bit adr_good(input logic [31:0] adr);
    return (adr[1:0] == 2'b00) && (adr < 32'(4 * DEPTH));
  endfunction

  task automatic push_probe(input logic [31:0] adr);
    exp_t e;
    inst_adr  = adr;
    probe_id++;
    e.tag     = probe_id;
    e.err     = err_m;
    e.cpu_rst = (m_mode != 2);
    e.done    = (m_mode == 2);
    e.ready   = (m_mode == 1);
    e.inst    = (m_mode == 2 && adr_good(adr)) ? mem_m[adr / 4] : 32'h0;
    sb.push_back(e);
    probe = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] adr);
    push_probe(adr);
    tick();
    if (m_mode == 2 && !adr_good(adr)) err_m = 1'b1;
    inst_adr = '0;
  endtask

  task automatic fetch_random;
    int k;
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0) begin
      a = $urandom;
      if (adr_good(a)) a = a | 32'h1;
      fetch(a);
    end else begin
      k = 0;
      for (int t = 0; t < 1000; t++) begin
        k = $urandom_range(0, DEPTH - 1);
        if (wr_m[k]) break;
        k = 0;
      end
      fetch(32'(k * 4));
    end
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    tick();
    rst    = 1'b1;
    m_mode = 0;
    err_m  = 1'b0;
    push_probe(32'h0);
    tick();
  endtask

  // Loads n words (clamped to DEPTH); abort_after >= 0 resets before that byte.
  task automatic do_load(input int n, input bit gaps, input bit inject_start, input int abort_after);
    int          le;
    logic [31:0] w;
    ld_len   = n[AW:0];
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    err_m    = 1'b0;
    le       = (n > DEPTH) ? DEPTH : n;
    if (le == 0) begin
      m_mode = 2;
      fetch(32'h0);
      return;
    end
    m_mode = 1;
    push_probe(32'h0);
    tick();
    w = '0;
    for (int i = 0; i < 4 * le; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      if (inject_start && i == 5) begin
        ld_start = 1'b1;
        ld_len   = (AW + 1)'($urandom_range(0, 2 * DEPTH - 1));
        tick();
        ld_start = 1'b0;
      end
      if (i == abort_after) begin
        do_reset();
        return;
      end
      ld_data  = (fixed_bytes.size() != 0) ? fixed_bytes.pop_front() : 8'($urandom);
      ld_valid = 1'b1;
      if (i == 4 * le - 1) push_probe(32'h0);
      w = {w[23:0], ld_data};
      tick();
      ld_valid = 1'b0;
      ld_data  = 8'hxx;
      if (i % 4 == 3) begin
        mem_m[i / 4] = w;
        wr_m[i / 4]  = 1'b1;
      end
    end
    m_mode = 2;
    fetch(32'(4 * (le - 1)));
  endtask

  task automatic push_fixed_pair;
    fixed_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
  endtask

  initial begin
    rst = 1'b0; ld_start = 1'b0; ld_len = '0; ld_data = '0; ld_valid = 1'b0;
    inst_adr = '0; probe = 1'b0; probe_id = 0; vectors = 0; miscompares = 0;
    m_mode = 0; err_m = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr_m[i] = 1'b0;

    do_reset();

    push_fixed_pair();
    do_load(2, 1'b0, 1'b0, -1);
    fetch(32'h0);
    fetch(32'h4);

    push_fixed_pair();
    do_load(2, 1'b1, 1'b0, -1);
    fetch(32'h0);
    fetch(32'h4);

    do_load(2, 1'b0, 1'b0, 3);
    fixed_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_load(1, 1'b0, 1'b0, -1);
    fetch(32'h0);
    fetch(32'h4);

    fetch(32'h402);
    fetch(32'h0);
    fetch(32'h6);
    fetch(32'h4);
    do_load(0, 1'b0, 1'b0, -1);
    fetch(32'h4);
    do_load(1, 1'b0, 1'b0, -1);
    fetch(32'h4);

    for (int r = 0; r < 6; r++) begin
      do_load($urandom_range(1, 8), 1'($urandom_range(0, 1)), (r == 2), -1);
      repeat (4) fetch_random();
    end

    do_load(511, 1'b0, 1'b0, -1);
    fetch(32'h3FC);
    fetch(32'h400);
    fetch(32'h0);

    tick();
    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter AW, default 8, word-address width; memory depth is 2**AW 32-bit words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 ld_start  input  1  one-cycle pulse that begins a program load.
REQ-005 ld_len  input  AW+1  number of words to load, sampled when ld_start is accepted.
REQ-006 ld_data  input  8  program byte, big-endian within each word.
REQ-007 ld_valid  input  1  ld_data is valid this cycle.
REQ-008 ld_ready  output  1  loader accepts a byte this cycle.
REQ-009 inst_adr  input  32  byte address from the CPU fetch port.
REQ-010 inst  output  32  instruction word returned to the CPU, combinational.
REQ-011 cpu_rst  output  1  active-high reset that holds the CPU while no program is running.
REQ-012 done  output  1  high while in RUN.
REQ-013 err  output  1  sticky fetch-error flag.

Function
REQ-014 States SHALL be IDLE, LOAD and RUN; cpu_rst=1 in IDLE and LOAD and 0 in RUN; cpu_rst and done decode directly from state.
REQ-015 IDLE + ld_start: next state LOAD; latch len = min(ld_len, 2**AW); clear byte_cnt (2 bits), word_cnt (AW+1 bits) and err.
REQ-016 IDLE + ld_start with ld_len=0: next state RUN directly; no memory writes.
REQ-017 ld_ready=1 only in LOAD; a byte is accepted on an edge where ld_valid & ld_ready.
REQ-018 Accepted bytes shift into a 32-bit assembly register: byte_cnt 0 goes to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0]; byte_cnt increments and wraps 3 to 0.
REQ-019 On the edge that accepts the byte with byte_cnt=3, mem[word_cnt] SHALL be written with the full word, including the current byte; word_cnt then increments.
REQ-020 When that write makes word_cnt equal len, next state is RUN: cpu_rst is low in the cycle after the final byte edge, and the word is readable in that same cycle.
REQ-021 ld_valid low in LOAD: nothing changes and no byte is duplicated or skipped; an arbitrary gap length is legal.
REQ-022 ld_start while in LOAD: ignored.
REQ-023 ld_start while in RUN: same action as REQ-015/REQ-016 (reload); cpu_rst rises in the next cycle; memory words beyond the new len keep their old contents.
REQ-024 inst in RUN: mem[inst_adr[AW+1:2]] when inst_adr[1:0]=0 and inst_adr[31:AW+2]=0; otherwise 0x00000000.
REQ-025 inst outside RUN: 0x00000000 (nop).
REQ-026 err is set on any RUN-state clock edge where inst_adr is misaligned or out of range; it stays set until reset or an accepted ld_start.
REQ-027 Memory read is asynchronous and memory write is synchronous, with no read-during-write hazard visible to the CPU (no writes in RUN).

Reset
REQ-028 While rst=0 at an edge: state=IDLE, byte_cnt=0, word_cnt=0, len=0, err=0, assembly register=0.
REQ-029 After reset: cpu_rst=1, done=0, ld_ready=0, inst=0.
REQ-030 Memory contents are not reset; reset during LOAD abandons the partial word and no write occurs.
REQ-031 rst has priority over ld_start and over byte acceptance in the same cycle.

Verification
REQ-032 Reset: hold rst=0 for 2 cycles -> cpu_rst=1, done=0, ld_ready=0, err=0, inst=0x00000000.
REQ-033 Load with ld_len=2 and bytes 20 08 00 05 AC 08 00 00 back-to-back -> RUN and cpu_rst=0 one cycle after the 8th byte; inst_adr=0 gives 0x20080005; inst_adr=4 gives 0xAC080000.
REQ-034 Same load with ld_valid low for 1-3 cycles between bytes -> identical words; RUN only after the 8th accepted byte.
REQ-035 rst=0 after 3 bytes of a load, then a new ld_len=1 load of 12 34 56 78 -> mem[0]=0x12345678; no stray partial word.
REQ-036 In RUN, inst_adr=0x402 or 0x00000006 (AW=8) -> inst=0 and err=1 persists; an accepted ld_start clears err.
REQ-037 ld_len=0 -> RUN on the next edge; a later ld_start in RUN -> LOAD with cpu_rst=1 next cycle and old words beyond the new len preserved.
